// File: rtl/phase_scheduler.sv
// phase_scheduler: two-road signal controller cycling all-red, protected left, green and yellow per road,
// with gap-out/max-out green exit, demand latches and a hold-able tick timebase.
module phase_scheduler #(
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int LEFT_T    = 5,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       hold,
    input  logic       sensor_ns,
    input  logic       sensor_ew,
    input  logic       left_req_ns,
    input  logic       left_req_ew,
    output logic [2:0] phase,
    output logic [3:0] ns_lamp,
    output logic [3:0] ew_lamp,
    output logic       phase_start
);
    typedef enum logic [2:0] {
        ALLRED_NS, NS_LEFT, NS_GREEN, NS_YELLOW,
        ALLRED_EW, EW_LEFT, EW_GREEN, EW_YELLOW
    } state_t;

    localparam logic [5:0] AR_END = 6'(ALLRED_T - 1);
    localparam logic [5:0] LT_END = 6'(LEFT_T - 1);
    localparam logic [5:0] YL_END = 6'(YELLOW_T - 1);
    localparam logic [5:0] G_MIN  = 6'(GREEN_MIN);
    localparam logic [5:0] G_MAX  = 6'(GREEN_MAX);

    state_t     state, next;
    logic [5:0] tcnt;
    logic       dem_ns, dem_ew, dem_left_ns, dem_left_ew;
    logic       tick_ev, trans, ns_out, ew_out;

    assign tick_ev = tick & ~hold;
    assign trans   = next != state;
    // Green exit needs no tick: it fires on any unheld cycle once the counter allows it.
    assign ns_out  = !hold && dem_ew && ((tcnt >= G_MIN && !sensor_ns) || tcnt >= G_MAX);
    assign ew_out  = !hold && dem_ns && ((tcnt >= G_MIN && !sensor_ew) || tcnt >= G_MAX);

    always_comb begin
        next = state;
        case (state)
            ALLRED_NS: if (tick_ev && tcnt == AR_END) next = dem_left_ns ? NS_LEFT : NS_GREEN;
            NS_LEFT:   if (tick_ev && tcnt == LT_END) next = NS_GREEN;
            NS_GREEN:  if (ns_out) next = NS_YELLOW;
            NS_YELLOW: if (tick_ev && tcnt == YL_END) next = ALLRED_EW;
            ALLRED_EW: if (tick_ev && tcnt == AR_END) next = dem_left_ew ? EW_LEFT : EW_GREEN;
            EW_LEFT:   if (tick_ev && tcnt == LT_END) next = EW_GREEN;
            EW_GREEN:  if (ew_out) next = EW_YELLOW;
            EW_YELLOW: if (tick_ev && tcnt == YL_END) next = ALLRED_NS;
            default:   next = ALLRED_NS;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ALLRED_NS;
            tcnt        <= 6'd0;
            dem_ns      <= 1'b0;
            dem_ew      <= 1'b0;
            dem_left_ns <= 1'b0;
            dem_left_ew <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            state       <= next;
            phase_start <= trans;
            tcnt        <= trans ? 6'd0 : (tick_ev && tcnt != 6'd63) ? tcnt + 6'd1 : tcnt;
            dem_ns      <= (trans && next == NS_GREEN) ? 1'b0 : (sensor_ns && state != NS_GREEN) ? 1'b1 : dem_ns;
            dem_ew      <= (trans && next == EW_GREEN) ? 1'b0 : (sensor_ew && state != EW_GREEN) ? 1'b1 : dem_ew;
            dem_left_ns <= (trans && next == NS_LEFT) ? 1'b0 : (left_req_ns && state != NS_LEFT) ? 1'b1 : dem_left_ns;
            dem_left_ew <= (trans && next == EW_LEFT) ? 1'b0 : (left_req_ew && state != EW_LEFT) ? 1'b1 : dem_left_ew;
        end
    end

    assign phase   = state;
    assign ns_lamp = state == NS_LEFT ? 4'b1000 : state == NS_GREEN ? 4'b0100 : state == NS_YELLOW ? 4'b0010 : 4'b0001;
    assign ew_lamp = state == EW_LEFT ? 4'b1000 : state == EW_GREEN ? 4'b0100 : state == EW_YELLOW ? 4'b0010 : 4'b0001;
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: scenario tasks for phase_scheduler; a scoreboard queue holds the phase expected
// at each phase_start pulse, and a monitor checks lamps against phase every cycle.
module tb_phase_scheduler;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0, hold = 1'b0;
    logic       sensor_ns = 1'b0, sensor_ew = 1'b0, left_req_ns = 1'b0, left_req_ew = 1'b0;
    logic [2:0] phase;
    logic [3:0] ns_lamp, ew_lamp;
    logic       phase_start;
    int         n_chk = 0, n_fail = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_p;

    phase_scheduler dut (
        .clk(clk), .resetn(resetn), .tick(tick), .hold(hold),
        .sensor_ns(sensor_ns), .sensor_ew(sensor_ew),
        .left_req_ns(left_req_ns), .left_req_ew(left_req_ew),
        .phase(phase), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lamp_ns(input logic [2:0] p);
        return p == 3'd1 ? 4'b1000 : p == 3'd2 ? 4'b0100 : p == 3'd3 ? 4'b0010 : 4'b0001;
    endfunction

    function automatic logic [3:0] lamp_ew(input logic [2:0] p);
        return p == 3'd5 ? 4'b1000 : p == 3'd6 ? 4'b0100 : p == 3'd7 ? 4'b0010 : 4'b0001;
    endfunction

    always @(negedge clk) begin
        n_chk++;
        if (ns_lamp !== lamp_ns(phase) || ew_lamp !== lamp_ew(phase)) begin
            n_fail++;
            $display("FAIL lamps: phase=%0d ns=%b ew=%b, required ns=%b ew=%b", phase, ns_lamp, ew_lamp, lamp_ns(phase), lamp_ew(phase));
        end
        if (phase_start === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: unexpected phase_start into phase %0d", phase);
            end else begin
                exp_p = exp_q.pop_front();
                if (phase !== exp_p) begin
                    n_fail++;
                    $display("FAIL scoreboard: entered phase %0d, required %0d", phase, exp_p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic chk_phase(input string name, input logic [2:0] want);
        n_chk++;
        if (phase !== want) begin
            n_fail++;
            $display("FAIL %s: phase=%0d required %0d", name, phase, want);
        end
    endtask

    // From EW_GREEN (tcnt 0): serve NS, request an EW left during NS_GREEN, and land in EW_LEFT.
    task automatic goto_ew_left();
        sensor_ns = 1'b1; step(); sensor_ns = 1'b0;
        exp_q.push_back(3'd7); tick_n(5); step();
        exp_q.push_back(3'd0); tick_n(3);
        exp_q.push_back(3'd2); tick_n(2);
        left_req_ew = 1'b1; step(); left_req_ew = 1'b0;
        sensor_ew = 1'b1; step(); sensor_ew = 1'b0;
        tick_n(5);
        exp_q.push_back(3'd3); step();
        exp_q.push_back(3'd4); tick_n(3);
        exp_q.push_back(3'd5); tick_n(2);
    endtask

    task automatic test_reset();
        #1;
        chk_phase("reset_phase", 3'd0);
        n_chk++;
        if (ns_lamp !== 4'b0001 || ew_lamp !== 4'b0001 || phase_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ns=%b ew=%b ps=%b required 0001 0001 0", ns_lamp, ew_lamp, phase_start);
        end
        step(); step();
        resetn = 1'b1;
        exp_q.push_back(3'd2);
        tick_n(1);
        chk_phase("reset_first_tick", 3'd0);
        tick_n(1);
        chk_phase("reset_to_green", 3'd2);
        n_chk++;
        if (ns_lamp !== 4'b0100 || ew_lamp !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_green_lamps: ns=%b ew=%b required 0100 0001", ns_lamp, ew_lamp);
        end
    endtask

    task automatic test_gap_out();
        tick_n(10);
        chk_phase("green_rest", 3'd2);
        sensor_ew = 1'b1; step(); sensor_ew = 1'b0;
        chk_phase("gap_latch_cycle", 3'd2);
        exp_q.push_back(3'd3); step();
        chk_phase("gap_out", 3'd3);
        exp_q.push_back(3'd4); tick_n(2);
        chk_phase("yellow_2", 3'd3);
        tick_n(1);
        chk_phase("yellow_done", 3'd4);
        exp_q.push_back(3'd6); tick_n(1);
        chk_phase("allred_1", 3'd4);
        tick_n(1);
        chk_phase("ew_green", 3'd6);
    endtask

    task automatic test_max_out();
        sensor_ns = 1'b1;
        exp_q.push_back(3'd7); tick_n(5);
        chk_phase("ew_min_green", 3'd6);
        step();
        chk_phase("ew_gap_out", 3'd7);
        exp_q.push_back(3'd0); tick_n(3);
        exp_q.push_back(3'd2); tick_n(2);
        chk_phase("ns_green_again", 3'd2);
        sensor_ew = 1'b1; step(); sensor_ew = 1'b0;
        tick_n(19);
        chk_phase("max_19", 3'd2);
        tick_n(1);
        chk_phase("max_20", 3'd2);
        exp_q.push_back(3'd3); step();
        chk_phase("max_out", 3'd3);
        sensor_ns = 1'b0;
    endtask

    task automatic test_hold();
        tick_n(1);
        hold = 1'b1;
        tick_n(10);
        hold = 1'b0;
        chk_phase("hold_phase", 3'd3);
        n_chk++;
        if (dut.tcnt !== 6'd1) begin
            n_fail++;
            $display("FAIL hold_tcnt: tcnt=%0d required 1", dut.tcnt);
        end
        tick_n(1);
        chk_phase("hold_resume", 3'd3);
        exp_q.push_back(3'd4); tick_n(1);
        chk_phase("hold_yellow_done", 3'd4);
        exp_q.push_back(3'd6); tick_n(2);
        chk_phase("hold_ew_green", 3'd6);
    endtask

    task automatic test_left();
        goto_ew_left();
        chk_phase("ew_left", 3'd5);
        n_chk++;
        if (ns_lamp !== 4'b0001 || ew_lamp !== 4'b1000 || dut.dem_left_ew !== 1'b0) begin
            n_fail++;
            $display("FAIL left_entry: ns=%b ew=%b dem_left_ew=%b required 0001 1000 0", ns_lamp, ew_lamp, dut.dem_left_ew);
        end
        tick_n(4);
        chk_phase("left_4", 3'd5);
        left_req_ew = 1'b1; step(); left_req_ew = 1'b0;
        n_chk++;
        if (dut.dem_left_ew !== 1'b0) begin
            n_fail++;
            $display("FAIL left_no_set_in_left: dem_left_ew=%b required 0", dut.dem_left_ew);
        end
        exp_q.push_back(3'd6); tick_n(1);
        chk_phase("left_done", 3'd6);
    endtask

    task automatic test_reset_mid();
        goto_ew_left();
        tick_n(2);
        sensor_ns = 1'b1; step(); sensor_ns = 1'b0;
        n_chk++;
        if (dut.dem_ns !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_dem_ns: dem_ns=%b required 1", dut.dem_ns);
        end
        resetn = 1'b0;
        #1;
        chk_phase("mid_reset_phase", 3'd0);
        n_chk++;
        if (ns_lamp !== 4'b0001 || ew_lamp !== 4'b0001 || phase_start !== 1'b0 || dut.tcnt !== 6'd0 ||
            {dut.dem_ns, dut.dem_ew, dut.dem_left_ns, dut.dem_left_ew} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_state: ns=%b ew=%b ps=%b tcnt=%0d dem=%b%b%b%b required 0001 0001 0 0 0000",
                     ns_lamp, ew_lamp, phase_start, dut.tcnt, dut.dem_ns, dut.dem_ew, dut.dem_left_ns, dut.dem_left_ew);
        end
        step();
        resetn = 1'b1;
        exp_q.push_back(3'd2);
        tick_n(1);
        chk_phase("mid_post_tick1", 3'd0);
        tick_n(1);
        chk_phase("mid_post_green", 3'd2);
    endtask

    initial begin
        test_reset();
        test_gap_out();
        test_max_out();
        test_hold();
        test_left();
        test_reset_mid();
        step(); step();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected phases never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
